// File: rtl/adder_seq_ctrl.sv
// Digit-serial add/subtract sequencer: one 2-bit adder slice walks LSB-first over a WIDTH-bit operand pair.
// Optional early exit once the carry and the remaining operand bits are all zero: define ADDSEQ_EARLY_DONE_EN.
module adder_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy,
  output logic             done
);
  localparam int DIGITS = WIDTH / 2;
  localparam int KW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  if ((WIDTH < 2) || (WIDTH % 2 != 0)) begin : g_bad_width
    $error("adder_seq_ctrl: WIDTH must be even and >= 2");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             c_q, c_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [KW-1:0]    k_q, k_d;

  logic [1:0] a_dig, b_dig;
  logic [2:0] slice;
  logic       last, early, accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      k_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      k_q     <= k_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // The single shared slice: digit k of each operand plus the running carry.
  always_comb begin
    a_dig = a_q[{k_q, 1'b0} +: 2];
    b_dig = b_q[{k_q, 1'b0} +: 2];
    slice = {1'b0, a_dig} + {1'b0, b_dig} + {2'b00, c_q};
    last  = (k_q == KW'(DIGITS - 1));
  end

`ifdef ADDSEQ_EARLY_DONE_EN
  logic [KW+1:0] shamt;
  always_comb begin
    shamt = {1'b0, k_q, 1'b0} + (KW+2)'(2);
    early = !slice[2] && (((a_q | b_q) >> shamt) == '0);
  end
`else
  always_comb early = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = start ? RUN : IDLE;
      RUN:        if (last || early) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    c_d    = c_q;
    k_d    = k_q;
    sum_d  = sum_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    accept = start && (state_q != RUN);
    if (accept) begin
      // Subtraction is A + ~B + 1, so carry_out=1 means no borrow.
      a_d    = in1;
      b_d    = sub ? ~in2 : in2;
      c_d    = sub ? 1'b1 : cin;
      k_d    = '0;
      sum_d  = '0;
      cout_d = 1'b0;
      ovf_d  = 1'b0;
    end else if (state_q == RUN) begin
      sum_d[{k_q, 1'b0} +: 2] = slice[1:0];
      c_d = slice[2];
      k_d = last ? '0 : k_q + KW'(1);
      if (last) begin
        cout_d = slice[2];
        ovf_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice[1] != a_q[WIDTH-1]);
      end
    end
  end

  always_comb begin
    sum       = sum_q;
    carry_out = cout_q;
    overflow  = ovf_q;
    busy      = (state_q == RUN);
    done      = (state_q == DONE);
  end
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed bench for adder_seq_ctrl (WIDTH=32, default build): results, latency, handshake, reset abort.
module tb_adder_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, sub = 1'b0, cin = 1'b0;
  logic [31:0] in1 = '0, in2 = '0;
  logic [31:0] sum;
  logic        carry_out, overflow, busy, done;

  int checks = 0;
  int errors = 0;

  adder_seq_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .cin(cin),
    .in1(in1), .in2(in2), .sum(sum), .carry_out(carry_out),
    .overflow(overflow), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at #1 after an edge; launches at the next edge, optionally pokes start
  // during RUN with junk operands, and checks latency, busy span and result.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic c, input bit noise,
                        input logic [31:0] es, input logic eco, input logic eov);
    int cnt, bcnt;
    in1 = a; in2 = b; sub = s; cin = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in1 = 32'hDEAD_BEEF; in2 = 32'h1234_5678;
    cnt = 0; bcnt = busy ? 1 : 0;
    while (cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
      if (done) break;
      if (busy) bcnt++;
      if (noise && (cnt == 2 || cnt == 9)) begin
        start = 1'b1; in1 = 32'hFFFF_FFFF; in2 = 32'hFFFF_FFFF; sub = ~s;
      end else if (noise) begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk({tag, ".lat"},  32'(cnt), 32'd16);
    chk({tag, ".busy"}, 32'(bcnt), 32'd16);
    chk({tag, ".sum"},  sum, es);
    chk({tag, ".co"},   {31'b0, carry_out}, {31'b0, eco});
    chk({tag, ".ov"},   {31'b0, overflow}, {31'b0, eov});
  endtask

  initial begin
    int seen;
    #1;
    chk("rst.sum",  sum, 32'h0);
    chk("rst.flags", {28'b0, carry_out, overflow, busy, done}, 32'h0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    run_op("add53",  32'h5,        32'h3, 1'b0, 1'b0, 1'b0, 32'h8,        1'b0, 1'b0);
    @(posedge clk); #1;
    chk("done.pulse", {30'b0, done, busy}, 32'h0);
    chk("hold.sum", sum, 32'h8);

    run_op("addco",  32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 1'b0);
    run_op("addcin", 32'h0,        32'h0, 1'b0, 1'b1, 1'b0, 32'h1,        1'b0, 1'b0);
    run_op("addov",  32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_op("sub53",  32'h5,        32'h3, 1'b1, 1'b0, 1'b0, 32'h2,        1'b1, 1'b0);
    run_op("sub35",  32'h3,        32'h5, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_op("subov",  32'h8000_0000, 32'h1, 1'b1, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);

    // Start pokes mid-RUN are ignored; then back-to-back issue straight from DONE.
    run_op("noise",  32'h0001_0000, 32'h0000_FFFF, 1'b0, 1'b0, 1'b1, 32'h0001_FFFF, 1'b0, 1'b0);
    run_op("b2b",    32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

    // Abort in the seventh RUN cycle.
    in1 = 32'hAAAA_AAAA; in2 = 32'h5555_5555; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    rst = 1'b1; start = 1'b1; #1;
    chk("abort.busy", {31'b0, busy}, 32'h0);
    chk("abort.sum",  sum, 32'h0);
    @(posedge clk); #1;
    chk("abort.rstwins", {30'b0, busy, done}, 32'h0);
    rst = 1'b0; start = 1'b0;
    seen = 0;
    repeat (20) begin @(posedge clk); #1; if (done || busy) seen++; end
    chk("abort.nodone", 32'(seen), 32'h0);
    run_op("post",   32'h1, 32'h1, 1'b0, 1'b0, 1'b0, 32'h2, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/adder_seq_ctrl.md
Name: adder_seq_ctrl

Overview:
- Digit-serial add/subtract sequencer for the datapath. It time-shares exactly one 2-bit ripple adder slice across a WIDTH-bit operand pair, two bits per cycle, LSB first.
- Intended for area-reduced multi-cycle ALU variants and address-offset computation where a full-width adder is not wanted.
- Provides a start/busy/done handshake, a carry register between digits, and signed-overflow detection.

Parameters:
- WIDTH, 32, operand width in bits. Must be even and at least 2.
- DIGITS, WIDTH/2, number of slice passes. Derived localparam; not overridable.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request. Sampled in IDLE or DONE only.
- sub  input  1  1 = in1 - in2; 0 = in1 + in2 + cin.
- cin  input  1  carry-in for add. Ignored when sub=1.
- in1  input  WIDTH  operand A. Latched on accepted start.
- in2  input  WIDTH  operand B. Latched on accepted start.
- sum  output  WIDTH  result register.
- carry_out  output  1  carry out of the MSB.
- overflow  output  1  two's-complement overflow.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result is valid.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-high, with ports named clk and rst.
- Reset values: state=IDLE; sum=0; carry_out=0; overflow=0; busy=0; done=0; digit counter=0; carry register=0; operand registers=0.
- FSM states are IDLE, RUN and DONE.
- Start acceptance: start=1 in IDLE or DONE at edge E0 does all of the following, then the state goes to RUN.
  - A_reg <= in1.
  - B_reg <= sub ? ~in2 : in2.
  - c_reg <= sub ? 1 : cin.
  - k <= 0.
  - sum <= 0.
  - carry_out <= 0.
  - overflow <= 0.
- start during RUN is ignored. Operand changes during RUN have no effect.
- Each RUN cycle:
  - The slice computes A_reg[2k+1:2k] + B_reg[2k+1:2k] + c_reg.
  - sum[2k+1:2k] <= slice sum.
  - c_reg <= slice carry.
  - k <= k+1.
- At the edge that processes k = DIGITS-1:
  - carry_out <= slice carry.
  - overflow <= (A_reg[MSB] == B_reg[MSB]) && (new sum[MSB] != A_reg[MSB]).
  - The state goes to DONE.
- Latency: done is high exactly DIGITS cycles after the E0 edge (16 for WIDTH=32), for one cycle. busy is high for exactly DIGITS cycles.
- DONE state:
  - done=1 and busy=0.
  - start=1 goes to RUN with new operands (back-to-back issue, no bubble beyond the done cycle). Otherwise the state goes to IDLE.
- sum, carry_out and overflow hold their values until the next accepted start.
- Subtraction carry_out follows the standard convention: 1 = no borrow.
- Width rules:
  - All arithmetic is modulo 2^WIDTH. No sign extension.
  - The counter is sized ceil(log2(DIGITS)) bits and never wraps past DIGITS-1 inside RUN.
- Reset mid-operation: rst asserted in any state returns everything to reset values immediately. No done pulse is produced for the aborted operation.
- Simultaneous rst and start: rst wins.

Optional Feature:
- Macro: ADDSEQ_EARLY_DONE_EN.
- When defined, the sequencer terminates early. After processing digit k, if both of the following hold, the state goes to DONE at that edge:
  - the new c_reg is 0;
  - A_reg and B_reg bits above 2k+1 are all zero.
- On early termination:
  - carry_out=0 and overflow=0.
  - The remaining sum bits stay 0, since they were cleared at start.
  - Latency becomes k+1 cycles, with a minimum of 1.
- When not defined, latency is always DIGITS cycles. No early-exit logic is synthesized.

Test Plan:
- Add, fixed latency: WIDTH=32, in1=0x00000005, in2=0x00000003, cin=0, sub=0. Expect sum=0x00000008, carry_out=0, overflow=0, and done exactly 16 cycles after start with busy high for 16 cycles. With ADDSEQ_EARLY_DONE_EN defined, done comes 2 cycles after start and the result is the same.
- Carry out: in1=0xFFFFFFFF, in2=0x00000001, cin=0. Expect sum=0x00000000, carry_out=1, overflow=0. With in1=in2=0 and cin=1, expect sum=0x00000001.
- Signed overflow: in1=0x7FFFFFFF, in2=0x00000001. Expect sum=0x80000000, carry_out=0, overflow=1.
- Subtract:
  - 5-3: sum=0x00000002, carry_out=1, overflow=0.
  - 3-5: sum=0xFFFFFFFE, carry_out=0.
  - 0x80000000-1: sum=0x7FFFFFFF, overflow=1.
- Handshake:
  - start pulses in RUN cycles 3 and 10 are ignored, and the result is unchanged.
  - start held high in the DONE cycle with new operands launches the next operation.
  - busy rises the cycle after DONE, and the second done arrives 16 cycles after that edge.
- Reset mid-operation: assert rst during RUN cycle 7. Expect busy=0, sum=0, no done pulse. A following start with in1=1, in2=1 yields sum=2 after 16 cycles.
